// File: rtl/leaf_port_adapter_pkg.sv
// leaf_port_adapter_pkg: default packet geometry and field positions for leaf network packets.
package leaf_port_adapter_pkg;
   localparam int LP_PAYLOAD_SZ = 43;
   localparam int LP_ADDR_SZ    = 5;
   localparam int LP_P_SZ       = 1 + LP_ADDR_SZ + LP_PAYLOAD_SZ;
   localparam int VALID_IDX     = LP_P_SZ - 1;
   localparam int ADDR_HI       = LP_P_SZ - 2;
   localparam int ADDR_LO       = LP_PAYLOAD_SZ;
   localparam int PAYLOAD_HI    = LP_PAYLOAD_SZ - 1;
   localparam int PAYLOAD_LO    = 0;
endpackage

// File: rtl/leaf_sync_fifo.sv
// leaf_sync_fifo: synchronous FIFO with wrap-bit pointers and a combinational head.
module leaf_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] head_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
   logic [W-1:0] mem_q [DEPTH];
   logic         do_push, do_pop;
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty_o = wr_q == rd_q;
   assign do_pop  = pop_i && !empty_o;
   // a pop frees the slot the write lands in, so full-with-pop still accepts
   assign do_push = push_i && (!full_o || do_pop);
   assign head_o  = mem_q[rd_q[AW-1:0]];
   assign wr_d    = wr_q + {{AW{1'b0}}, do_push};
   assign rd_d    = rd_q + {{AW{1'b0}}, do_pop};
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
   end
endmodule

// File: rtl/leaf_port_adapter.sv
// leaf_port_adapter: PE-side adapter to a leaf network port with TX resend and RX buffering.
module leaf_port_adapter
   import leaf_port_adapter_pkg::*;
#(
   parameter int P_SZ       = LP_P_SZ,
   parameter int PAYLOAD_SZ = LP_PAYLOAD_SZ,
   parameter int ADDR_SZ    = LP_ADDR_SZ,
   parameter int TX_DEPTH   = 4,
   parameter int RX_DEPTH   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic [ADDR_SZ-1:0]    tx_addr,
   input  logic [PAYLOAD_SZ-1:0] tx_payload,
   output logic [P_SZ-1:0]       dout_leaf,
   input  logic                  resend,
   input  logic [P_SZ-1:0]       din_leaf,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic [PAYLOAD_SZ-1:0] rx_payload,
   output logic                  rx_overflow
);
   localparam int E_SZ = ADDR_SZ + PAYLOAD_SZ;
   logic [E_SZ-1:0] tx_head;
   logic [P_SZ-1:0] dout_q, dout_d;
   logic            tx_full, tx_empty, tx_pop, hold;
   logic            rx_full, rx_empty, rx_push, rx_pop;
   logic            ovf_q, ovf_d;
   logic            unused_din_addr;
   assign tx_ready = !tx_full;
   // dout_q doubles as the last sent packet; its valid bit is last_valid
   assign hold     = resend && dout_q[P_SZ-1];
   assign tx_pop   = !hold && !tx_empty;
   assign dout_d   = hold ? dout_q : tx_empty ? '0 : {1'b1, tx_head};
   assign rx_push  = din_leaf[P_SZ-1];
   assign rx_valid = !rx_empty;
   assign rx_pop   = rx_valid && rx_ready;
   assign ovf_d    = ovf_q || (rx_push && rx_full && !rx_pop);
   assign unused_din_addr = ^din_leaf[P_SZ-2:PAYLOAD_SZ];
   leaf_sync_fifo #(.W(E_SZ), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (tx_valid && tx_ready),
      .pop_i   (tx_pop),
      .din_i   ({tx_addr, tx_payload}),
      .head_o  (tx_head),
      .full_o  (tx_full),
      .empty_o (tx_empty)
   );
   leaf_sync_fifo #(.W(PAYLOAD_SZ), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (rx_push),
      .pop_i   (rx_pop),
      .din_i   (din_leaf[PAYLOAD_SZ-1:0]),
      .head_o  (rx_payload),
      .full_o  (rx_full),
      .empty_o (rx_empty)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         dout_q <= dout_d;
         ovf_q  <= ovf_d;
      end
   end
   assign dout_leaf   = dout_q;
   assign rx_overflow = ovf_q;
endmodule

// File: tb/tb_leaf_port_adapter.sv
// tb_leaf_port_adapter: directed scenarios plus random traffic checked against a queue-based model.
module tb_leaf_port_adapter;
   localparam int P = 49, PL = 43, A = 5, TXD = 4, RXD = 8;
   logic          clk = 1'b0, reset = 1'b0;
   logic          tx_valid = 1'b0, resend = 1'b0, rx_ready = 1'b0;
   logic [A-1:0]  tx_addr = '0;
   logic [PL-1:0] tx_payload = '0;
   logic [P-1:0]  din_leaf = '0;
   logic          tx_ready, rx_valid, rx_overflow;
   logic [P-1:0]  dout_leaf;
   logic [PL-1:0] rx_payload;
   logic [P-2:0]  txq [$];
   logic [PL-1:0] rxq [$];
   logic [P-1:0]  m_dout = '0;
   logic          m_last = 1'b0, m_ovf = 1'b0;
   int            n_cmp = 0, n_err = 0;
   logic [63:0]   r;

   always #5 clk = ~clk;

   leaf_port_adapter #(.P_SZ(P), .PAYLOAD_SZ(PL), .ADDR_SZ(A), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
      .clk         (clk),
      .reset       (reset),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_addr     (tx_addr),
      .tx_payload  (tx_payload),
      .dout_leaf   (dout_leaf),
      .resend      (resend),
      .din_leaf    (din_leaf),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .rx_payload  (rx_payload),
      .rx_overflow (rx_overflow)
   );

   // Reference: TX/RX buffers as queues, output register and last packet as plain state.
   always @(posedge clk or negedge reset) begin : model
      bit acc, rpop, rfull;
      if (!reset) begin
         txq.delete();
         rxq.delete();
         m_dout <= '0;
         m_last <= 1'b0;
         m_ovf  <= 1'b0;
      end else begin
         acc   = tx_valid && (txq.size() < TXD);
         rpop  = rx_ready && (rxq.size() > 0);
         rfull = rxq.size() == RXD;
         if (!(resend && m_last)) begin
            if (txq.size() > 0) begin
               m_dout <= {1'b1, txq.pop_front()};
               m_last <= 1'b1;
            end else begin
               m_dout <= '0;
               m_last <= 1'b0;
            end
         end
         if (acc) txq.push_back({tx_addr, tx_payload});
         if (rpop) void'(rxq.pop_front());
         if (din_leaf[P-1]) begin
            if (rfull && !rpop) m_ovf <= 1'b1;
            else rxq.push_back(din_leaf[PL-1:0]);
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("tx_ready", 64'(tx_ready), 64'(txq.size() < TXD));
      chk("rx_valid", 64'(rx_valid), 64'(rxq.size() != 0));
      chk("dout_leaf", 64'(dout_leaf), 64'(m_dout));
      chk("rx_overflow", 64'(rx_overflow), 64'(m_ovf));
      if (rxq.size() != 0) chk("rx_payload", 64'(rx_payload), 64'(rxq[0]));
   endtask

   // Advance one cycle: model compare at the falling edge, then return 2ns after the rising edge.
   task automatic cyc();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      #2;
   endtask

   initial begin
      repeat (2) cyc();
      reset = 1'b1;
      cyc();
      chk("reset tx_ready", 64'(tx_ready), 64'd1);
      chk("reset dout", 64'(dout_leaf), 64'd0);
      // single send
      tx_valid = 1'b1; tx_addr = 5'd5; tx_payload = 43'h123;
      cyc();
      tx_valid = 1'b0;
      chk("single lat1", 64'(dout_leaf), 64'd0);
      cyc();
      chk("single dout", 64'(dout_leaf), 64'({1'b1, 5'd5, 43'h123}));
      chk("single model", 64'(m_dout), 64'({1'b1, 5'd5, 43'h123}));
      cyc();
      chk("single idle", 64'(dout_leaf), 64'd0);
      // resend A,A,A,B
      tx_valid = 1'b1; tx_addr = 5'd1; tx_payload = 43'hA;
      cyc();
      tx_addr = 5'd2; tx_payload = 43'hB;
      cyc();
      tx_valid = 1'b0;
      chk("resend A0", 64'(dout_leaf), 64'({1'b1, 5'd1, 43'hA}));
      resend = 1'b1;
      cyc();
      chk("resend A1", 64'(dout_leaf), 64'({1'b1, 5'd1, 43'hA}));
      cyc();
      chk("resend A2", 64'(dout_leaf), 64'({1'b1, 5'd1, 43'hA}));
      resend = 1'b0;
      cyc();
      chk("resend B", 64'(dout_leaf), 64'({1'b1, 5'd2, 43'hB}));
      chk("resend model B", 64'(m_dout), 64'({1'b1, 5'd2, 43'hB}));
      cyc();
      // backpressure under held resend
      tx_valid = 1'b1; tx_addr = 5'd3; tx_payload = 43'h500;
      cyc();
      tx_valid = 1'b0;
      cyc();
      resend = 1'b1;
      tx_addr = 5'd7;
      for (int k = 0; k < 4; k++) begin
         tx_valid = 1'b1;
         tx_payload = 43'(43'h600 + k);
         chk("bp ready", 64'(tx_ready), 64'd1);
         cyc();
      end
      tx_payload = 43'h604;
      chk("bp full", 64'(tx_ready), 64'd0);
      cyc();
      chk("bp still full", 64'(tx_ready), 64'd0);
      chk("bp held", 64'(dout_leaf), 64'({1'b1, 5'd3, 43'h500}));
      resend = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc();
         if (k == 1) tx_valid = 1'b0;
         chk("bp order", 64'(dout_leaf), 64'({1'b1, 5'd7, 43'(43'h600 + k)}));
      end
      cyc();
      // RX overflow
      rx_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         din_leaf = {1'b1, 5'(i), 43'(43'h7000 + i)};
         cyc();
      end
      din_leaf = '0;
      chk("rx ovf set", 64'(rx_overflow), 64'd1);
      chk("rx ovf model", 64'(m_ovf), 64'd1);
      rx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("rx drain", 64'(rx_payload), 64'(43'(43'h7000 + i)));
         cyc();
      end
      rx_ready = 1'b0;
      chk("rx empty", 64'(rx_valid), 64'd0);
      chk("rx ovf sticky", 64'(rx_overflow), 64'd1);
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      chk("ovf cleared", 64'(rx_overflow), 64'd0);
      // RX full with simultaneous pop
      for (int i = 0; i < 8; i++) begin
         din_leaf = {1'b1, 5'd9, 43'(43'h8000 + i)};
         cyc();
      end
      rx_ready = 1'b1;
      din_leaf = {1'b1, 5'd9, 43'h8100};
      cyc();
      din_leaf = '0;
      rx_ready = 1'b0;
      chk("full+pop no ovf", 64'(rx_overflow), 64'd0);
      chk("full+pop head", 64'(rx_payload), 64'(43'h8001));
      rx_ready = 1'b1;
      repeat (8) cyc();
      rx_ready = 1'b0;
      chk("full+pop drained", 64'(rx_valid), 64'd0);
      // reset during resend with both FIFOs occupied
      tx_valid = 1'b1; tx_addr = 5'd4; tx_payload = 43'h900;
      cyc();
      tx_payload = 43'h901;
      cyc();
      resend = 1'b1;
      tx_payload = 43'h902;
      din_leaf = {1'b1, 5'd0, 43'h77};
      cyc();
      tx_valid = 1'b0;
      din_leaf = '0;
      chk("pre-reset busy", 64'(rx_valid), 64'd1);
      reset = 1'b0;
      #1;
      chk("rst dout", 64'(dout_leaf), 64'd0);
      chk("rst rx_valid", 64'(rx_valid), 64'd0);
      chk("rst tx_ready", 64'(tx_ready), 64'd1);
      cyc();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("post-reset quiet", 64'(dout_leaf), 64'd0);
      end
      resend = 1'b0;
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         r = {$urandom, $urandom};
         tx_valid = 1'($urandom_range(0, 1));
         tx_addr = r[PL+A-1:PL];
         tx_payload = r[PL-1:0];
         resend = $urandom_range(0, 9) < 3;
         r = {$urandom, $urandom};
         din_leaf = {1'($urandom_range(0, 9) < 4), r[P-2:0]};
         rx_ready = ((i / 400) % 2 == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
         if ($urandom_range(0, 399) == 0) begin
            reset = 1'b0;
            cyc();
            reset = 1'b1;
         end
         cyc();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
